uart_sprite_ctrl: RTL and testbench

Parametrised multi-object sprite controller and renderer for the VGA demo top. Decodes received UART bytes into select, move, mode and reset commands for NUM_OBJ rectangular objects. Renders a white border plus the objects as 2-bit-per-channel RGB from the VGA pixel coordinates. Pending positions are double-buffered and committed once per frame, so a moving object never tears mid-frame.

---
 rtl/uart_sprite_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_sprite_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sprite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sprite_ctrl
//  Description : Multi-object sprite controller and renderer. Decodes UART
//                command bytes into select / move / mode / reset actions for
//                NUM_OBJ rectangles. It also renders a white border plus the
//                objects as 2-bit-per-channel RGB for the VGA pixel stream.
//                Pending positions are committed to the displayed set once per
//                frame, which prevents tearing.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                rx_data/valid   - received UART byte and 1-cycle strobe
//                x, y, blank     - pixel coordinate and blanking from timing
//                frame_start     - 1-cycle pulse at the start of each frame
//                R, G, B         - registered colour (1 cycle after x/y/blank)
//                sel             - index of the selected object
//                wrap_mode       - edge mode (1 = wrap, 0 = clamp)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sprite_ctrl #(
  parameter int NUM_OBJ      = 4,
  parameter int OBJ_W        = 100,
  parameter int OBJ_H        = 100,
  parameter int STEP         = 4,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 10,
  parameter int COORD_W      = 10,
  parameter bit WRAP_DEFAULT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               blank,
  input  logic               frame_start,
  output logic [1:0]         R,
  output logic [1:0]         G,
  output logic [1:0]         B,
  output logic [3:0]         sel,
  output logic               wrap_mode
);

  localparam int CW1 = COORD_W + 1;

  // Edge arithmetic runs one bit wider than a coordinate; the extra MSB
  // flags a result that went below zero.
  localparam logic [COORD_W:0] C_STEP  = CW1'(STEP);
  localparam logic [COORD_W:0] C_H_RES = CW1'(H_RES);
  localparam logic [COORD_W:0] C_V_RES = CW1'(V_RES);
  localparam logic [COORD_W:0] C_X_MAX = CW1'(H_RES - OBJ_W);
  localparam logic [COORD_W:0] C_Y_MAX = CW1'(V_RES - OBJ_H);
  localparam logic [COORD_W:0] C_OBJ_W = CW1'(OBJ_W);
  localparam logic [COORD_W:0] C_OBJ_H = CW1'(OBJ_H);
  localparam logic [COORD_W-1:0] C_Y_RST = COORD_W'((V_RES - OBJ_H) / 2);

  localparam logic [COORD_W-1:0] C_BRD_L = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] C_BRD_R = COORD_W'(H_RES - BORDER);
  localparam logic [COORD_W-1:0] C_BRD_B = COORD_W'(V_RES - BORDER);

  // Command bytes
  localparam logic [7:0] CMD_UP    = 8'd119;  // 'w'
  localparam logic [7:0] CMD_DOWN  = 8'd115;  // 's'
  localparam logic [7:0] CMD_LEFT  = 8'd97;   // 'a'
  localparam logic [7:0] CMD_RIGHT = 8'd100;  // 'd'
  localparam logic [7:0] CMD_MODE  = 8'd109;  // 'm'
  localparam logic [7:0] CMD_RST   = 8'd114;  // 'r'

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [COORD_W-1:0] rst_x(input int idx);
    return COORD_W'((H_RES / NUM_OBJ) * idx);
  endfunction

  // One move step with either clamp or wrap edge handling.
  function automatic logic [COORD_W-1:0] move_coord(
    input logic [COORD_W-1:0] cur,
    input logic               dec,
    input logic               wrap,
    input logic [COORD_W:0]   span,
    input logic [COORD_W:0]   max_pos
  );
    logic [COORD_W:0] v;
    v = dec ? ({1'b0, cur} - C_STEP) : ({1'b0, cur} + C_STEP);
    if (wrap) begin
      // Adding span to a negative two's-complement value lands on the
      // correct wrapped coordinate modulo 2^(COORD_W+1).
      if (v[COORD_W])   v = v + span;
      else if (v >= span) v = v - span;
    end else begin
      if (v[COORD_W])      v = '0;
      else if (v > max_pos) v = max_pos;
    end
    return v[COORD_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  logic       is_digit;
  logic [3:0] digit;
  logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_mode, cmd_rst;

  assign is_digit  = (rx_data >= 8'd48) && (rx_data <= 8'd57);
  assign digit     = rx_data[3:0];  // '0' is 0x30, so the low nibble is the digit
  assign cmd_up    = (rx_data == CMD_UP);
  assign cmd_down  = (rx_data == CMD_DOWN);
  assign cmd_left  = (rx_data == CMD_LEFT);
  assign cmd_right = (rx_data == CMD_RIGHT);
  assign cmd_mode  = (rx_data == CMD_MODE);
  assign cmd_rst   = (rx_data == CMD_RST);

  // --------------------------------------------------------------------------
  // Position state: pending (edited by commands) and displayed (rendered)
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] pend_x [NUM_OBJ];
  logic [COORD_W-1:0] pend_y [NUM_OBJ];
  logic [COORD_W-1:0] disp_x [NUM_OBJ];
  logic [COORD_W-1:0] disp_y [NUM_OBJ];

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= 4'd0;
      wrap_mode <= WRAP_DEFAULT;
      for (int i = 0; i < NUM_OBJ; i++) begin
        pend_x[i] <= rst_x(i);
        pend_y[i] <= C_Y_RST;
        disp_x[i] <= rst_x(i);
        disp_y[i] <= C_Y_RST;
      end
    end else begin
      // Commit reads the pending values from before this edge, so a command
      // arriving with frame_start waits for the following frame.
      if (frame_start) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          disp_x[i] <= pend_x[i];
          disp_y[i] <= pend_y[i];
        end
      end
      if (rx_valid) begin
        if (is_digit && (int'(digit) < NUM_OBJ)) sel <= digit;
        if (cmd_mode) wrap_mode <= ~wrap_mode;
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (cmd_rst) begin
            pend_x[i] <= rst_x(i);
            pend_y[i] <= C_Y_RST;
          end else if (sel == 4'(i)) begin
            if (cmd_up)
              pend_y[i] <= move_coord(pend_y[i], 1'b1, wrap_mode, C_V_RES, C_Y_MAX);
            if (cmd_down)
              pend_y[i] <= move_coord(pend_y[i], 1'b0, wrap_mode, C_V_RES, C_Y_MAX);
            if (cmd_left)
              pend_x[i] <= move_coord(pend_x[i], 1'b1, wrap_mode, C_H_RES, C_X_MAX);
            if (cmd_right)
              pend_x[i] <= move_coord(pend_x[i], 1'b0, wrap_mode, C_H_RES, C_X_MAX);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hit test: done one bit wider so an object near the right/bottom edge is
  // clipped rather than appearing again at the opposite side.
  // --------------------------------------------------------------------------
  logic [NUM_OBJ-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
      logic [COORD_W:0] xe, ye, ox, oy;
      assign xe = {1'b0, x};
      assign ye = {1'b0, y};
      assign ox = {1'b0, disp_x[gi]};
      assign oy = {1'b0, disp_y[gi]};
      assign hit[gi] = (xe >= ox) && (xe < ox + C_OBJ_W) &&
                       (ye >= oy) && (ye < oy + C_OBJ_H);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Colour selection
  // --------------------------------------------------------------------------
  logic       border;
  logic       obj_hit;
  logic [1:0] obj_r, obj_g, obj_b;
  logic [1:0] lvl;
  logic [1:0] nxt_r, nxt_g, nxt_b;

  assign border = (x < C_BRD_L) || (x >= C_BRD_R) || (y < C_BRD_L) || (y >= C_BRD_B);

  // Scanning from the highest index down leaves the lowest-index hit in place.
  always_comb begin
    obj_hit = 1'b0;
    obj_r   = 2'b00;
    obj_g   = 2'b00;
    obj_b   = 2'b00;
    lvl     = 2'b00;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        obj_hit = 1'b1;
        lvl     = (sel == 4'(i)) ? 2'b11 : 2'b01;
        obj_r   = 2'b00;
        obj_g   = 2'b00;
        obj_b   = 2'b00;
        case (i % 4)
          0:       obj_g = lvl;
          1:       obj_r = lvl;
          2:       obj_b = lvl;
          default: begin
            obj_r = lvl;
            obj_g = lvl;
          end
        endcase
      end
    end
  end

  always_comb begin
    nxt_r = 2'b00;
    nxt_g = 2'b00;
    nxt_b = 2'b00;
    if (blank) begin
      nxt_r = 2'b00;
    end else if (border) begin
      nxt_r = 2'b11;
      nxt_g = 2'b11;
      nxt_b = 2'b11;
    end else if (obj_hit) begin
      nxt_r = obj_r;
      nxt_g = obj_g;
      nxt_b = obj_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      R <= 2'b00;
      G <= 2'b00;
      B <= 2'b00;
    end else begin
      R <= nxt_r;
      G <= nxt_g;
      B <= nxt_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_sprite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_sprite_ctrl
//  Description : Scoreboard testbench for uart_sprite_ctrl. The driver applies
//                directed and random commands and pixel probes and pushes the
//                expected {R,G,B,sel,wrap_mode} for each probe. A monitor pops
//                each entry one cycle later and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sprite_ctrl;

  localparam int NUM_OBJ      = 4;
  localparam int OBJ_W        = 100;
  localparam int OBJ_H        = 100;
  localparam int STEP         = 4;
  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int BORDER       = 10;
  localparam int COORD_W      = 10;
  localparam bit WRAP_DEFAULT = 1'b0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic [9:0]   x = '0;
  logic [9:0]   y = '0;
  logic         blank = 1'b0;
  logic         frame_start = 1'b0;
  logic [1:0]   R, G, B;
  logic [3:0]   sel;
  logic         wrap_mode;

  always #5 clk = ~clk;

  uart_sprite_ctrl #(
    .NUM_OBJ(NUM_OBJ), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .STEP(STEP),
    .H_RES(H_RES), .V_RES(V_RES), .BORDER(BORDER), .COORD_W(COORD_W),
    .WRAP_DEFAULT(WRAP_DEFAULT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .x(x), .y(y), .blank(blank), .frame_start(frame_start),
    .R(R), .G(G), .B(B), .sel(sel), .wrap_mode(wrap_mode)
  );

  // --------------------------------------------------------------------------
  // Behavioural reference model
  // --------------------------------------------------------------------------
  int m_px [NUM_OBJ];
  int m_py [NUM_OBJ];
  int d_px [NUM_OBJ];
  int d_py [NUM_OBJ];
  int m_sel;
  bit m_wrap;

  function automatic void model_reset_pending();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_px[i] = (H_RES / NUM_OBJ) * i;
      m_py[i] = (V_RES - OBJ_H) / 2;
    end
  endfunction

  function automatic void model_reset();
    model_reset_pending();
    for (int i = 0; i < NUM_OBJ; i++) begin
      d_px[i] = m_px[i];
      d_py[i] = m_py[i];
    end
    m_sel  = 0;
    m_wrap = WRAP_DEFAULT;
  endfunction

  function automatic int mv(int v, int d, int span, int maxp);
    int r;
    r = v + d;
    if (m_wrap) begin
      if (r < 0) r = r + span;
      else if (r >= span) r = r - span;
    end else begin
      if (r < 0) r = 0;
      else if (r > maxp) r = maxp;
    end
    return r;
  endfunction

  function automatic void model_cmd(int b);
    if (b >= 48 && b <= 57) begin
      if (b - 48 < NUM_OBJ) m_sel = b - 48;
    end else if (b == 119) m_py[m_sel] = mv(m_py[m_sel], -STEP, V_RES, V_RES - OBJ_H);
    else if (b == 115) m_py[m_sel] = mv(m_py[m_sel], STEP, V_RES, V_RES - OBJ_H);
    else if (b == 97)  m_px[m_sel] = mv(m_px[m_sel], -STEP, H_RES, H_RES - OBJ_W);
    else if (b == 100) m_px[m_sel] = mv(m_px[m_sel], STEP, H_RES, H_RES - OBJ_W);
    else if (b == 109) m_wrap = !m_wrap;
    else if (b == 114) model_reset_pending();
  endfunction

  function automatic logic [5:0] model_rgb(int px, int py, bit bl);
    int r, g, b, lv;
    r = 0; g = 0; b = 0;
    if (bl) return 6'b0;
    if (px < BORDER || px >= H_RES - BORDER || py < BORDER || py >= V_RES - BORDER)
      return 6'b111111;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (px >= d_px[i] && px < d_px[i] + OBJ_W && py >= d_py[i] && py < d_py[i] + OBJ_H) begin
        lv = (i == m_sel) ? 3 : 1;
        case (i % 4)
          0: g = lv;
          1: r = lv;
          2: b = lv;
          default: begin r = lv; g = lv; end
        endcase
        return {2'(r), 2'(g), 2'(b)};
      end
    end
    return 6'b0;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [10:0] exp;  // {R,G,B,sel,wrap_mode}
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic probe = 1'b0;
  logic probe_d = 1'b0;

  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (probe_d) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %b with empty queue", {R, G, B, sel, wrap_mode});
      end else begin
        e = sbq.pop_front();
        if ({R, G, B, sel, wrap_mode} !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got RGB=%b_%b_%b sel=%0d wrap=%b, want RGB=%b_%b_%b sel=%0d wrap=%b",
                   e.name, R, G, B, sel, wrap_mode,
                   e.exp[10:9], e.exp[8:7], e.exp[6:5], e.exp[4:1], e.exp[0]);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, with the model advanced to match
  // --------------------------------------------------------------------------
  task automatic cycle(input int b, input bit rv, input bit fs, input bit rst,
                       input bit do_probe, input int px, input int py, input bit bl,
                       input string name);
    exp_t       e;
    logic [5:0] rgb;
    @(negedge clk);
    rx_data     = 8'(b);
    rx_valid    = rv;
    frame_start = fs;
    reset       = rst;
    x           = 10'(px);
    y           = 10'(py);
    blank       = bl;
    probe       = do_probe;
    rgb = model_rgb(px, py, bl);  // colour uses state before this edge
    if (rst) begin
      model_reset();
      rgb = 6'b0;
    end else begin
      if (fs) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          d_px[i] = m_px[i];
          d_py[i] = m_py[i];
        end
      end
      if (rv) model_cmd(b);
    end
    if (do_probe) begin
      e.name = name;
      e.exp  = {rgb, 4'(m_sel), m_wrap};
      sbq.push_back(e);
    end
  endtask

  task automatic send(input int b);
    cycle(b, 1, 0, 0, 0, 0, 0, 0, "");
  endtask

  task automatic send_n(input int b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic frame();
    cycle(0, 0, 1, 0, 0, 0, 0, 0, "");
  endtask

  task automatic pix(input int px, input int py, input string name);
    cycle(0, 0, 0, 0, 1, px, py, 0, name);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int cmds[16] = '{48, 49, 50, 51, 55, 57, 119, 115, 97, 100, 100, 97, 109, 114, 65, 0};

  initial begin
    model_reset();
    cycle(0, 1, 0, 1, 1, 170, 200, 0, "reset_state");
    cycle(0, 0, 0, 1, 0, 0, 0, 0, "");

    pix(170, 200, "obj1_unselected");
    pix(5, 200, "left_border");
    pix(300, 5, "top_border");
    cycle(0, 0, 0, 0, 1, 170, 200, 1, "blank_forces_black");

    // Move object 1 right by 5 steps.
    send(49);
    send_n(100, 5);
    pix(179, 200, "obj1_before_commit");
    frame();
    pix(279, 200, "obj1_right_edge");
    pix(280, 200, "obj1_past_edge");
    pix(179, 200, "obj1_left_gap");

    // Clamp mode limits.
    send(48);
    send(97);
    frame();
    pix(10, 200, "clamp_left");
    send_n(119, 48);
    frame();
    pix(50, 10, "clamp_top");
    send_n(115, 200);
    frame();
    pix(50, 469, "clamp_bottom_in");
    pix(50, 379, "clamp_bottom_gap");

    // Wrap mode on the x axis.
    send(114);
    send(109);
    send(48);
    send(97);
    frame();
    pix(637, 200, "wrap_right_border");
    pix(5, 200, "wrap_left_border");
    pix(629, 200, "wrap_clipped_black");
    pix(50, 200, "wrap_obj0_gone");

    // Overlap priority: object 2 moved onto object 3.
    send(50);
    send_n(100, 40);
    frame();
    pix(500, 200, "overlap_priority");

    // Command coinciding with frame_start commits the old value.
    send(109);
    send(114);
    frame();
    send(48);
    cycle(100, 1, 1, 0, 0, 0, 0, 0, "");
    pix(102, 200, "same_cycle_old_pos");
    frame();
    pix(102, 200, "same_cycle_next_frame");

    // Invalid select digit.
    send(55);
    pix(170, 200, "sel_digit_too_big");

    // Reset mid-frame with rx_valid asserted.
    send(49);
    send_n(115, 3);
    frame();
    cycle(109, 1, 0, 1, 1, 170, 200, 0, "mid_frame_reset");
    pix(170, 200, "post_reset_obj1");
    pix(480, 190, "post_reset_obj3");

    // Randomized phase.
    for (int it = 0; it < 1500; it++) begin
      int r, j, px, py;
      r = $urandom_range(0, 99);
      if (r < 60) cycle(cmds[$urandom_range(0, 15)], 1, ($urandom_range(0, 7) == 0), 0, 0, 0, 0, 0, "");
      else if (r < 70) frame();
      else if (r < 71) cycle(0, 0, 0, 1, 0, 0, 0, 0, "");
      else if (r < 85) begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
        cycle(0, 0, 0, 0, 1, px, py, ($urandom_range(0, 9) == 0), "rand_pixel");
      end else begin
        j  = $urandom_range(0, NUM_OBJ - 1);
        px = d_px[j] + (($urandom_range(0, 1) == 1) ? OBJ_W : 0) - $urandom_range(0, 1);
        py = d_py[j] + (($urandom_range(0, 1) == 1) ? OBJ_H : 0) - $urandom_range(0, 1);
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px > 1023) px = 1023;
        if (py > 1023) py = 1023;
        pix(px, py, "rand_edge");
      end
    end

    cycle(0, 0, 0, 0, 0, 0, 0, 0, "");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "");
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
